// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_CLEANUP
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-stage synchronizer bringing the asynchronous serial line into the
// i_Clock domain. Resets to the line's idle level so no false start is seen.
module uart_rx_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_Async,
    output logic o_Sync
);

    logic [STAGES-1:0] sync_ff;

    // Shift the raw line through the flop chain; the last stage is the safe copy.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync_ff <= {STAGES{RESET_VAL}};
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], i_Async};
        end
    end

    assign o_Sync = sync_ff[STAGES-1];

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with valid/ready output, parity and framing
// checks, and a sticky overrun flag for frames dropped while a word is held.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// RX_IDLE    | line idle, waiting for a synchronized low
// RX_START   | confirming the start bit at its midpoint (glitch filter)
// RX_DATA    | sampling DATA_BITS data bits, LSB first
// RX_PARITY  | sampling the parity bit (never entered with no parity)
// RX_STOP    | sampling STOP_BITS stop bits; last one completes the frame
// RX_CLEANUP | waiting for the line to return high (break holds here)
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic                 i_Rx_Serial,
    output logic [DATA_BITS-1:0] o_Rx_Data,
    output logic                 o_Rx_Valid,
    input  logic                 i_Rx_Ready,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Overrun,
    output logic                 o_Busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic          ODD_INV   = (PARITY_MODE == PARITY_ODD);

    rx_state_t            state;
    logic [CW-1:0]        bit_cnt;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit;
    logic                 frame_err_acc;
    logic                 rx_sync;

    logic sample_pt;
    logic parity_err_calc;
    logic frame_err_calc;
    logic handshake;

    uart_rx_sync #(
        .STAGES    (2),
        .RESET_VAL (1'b1)
    ) u_sync (
        .i_Clock (i_Clock),
        .i_Rst_n (i_Rst_n),
        .i_Async (i_Rx_Serial),
        .o_Sync  (rx_sync)
    );

    assign sample_pt       = (bit_cnt == CNT_LAST);
    assign parity_err_calc = (PARITY_MODE == PARITY_NONE) ? 1'b0
                           : ((^shift_reg) ^ parity_bit ^ ODD_INV);
    // The final stop sample is folded in directly so the flag is ready on the completing edge.
    assign frame_err_calc  = frame_err_acc | ~rx_sync;
    assign handshake       = o_Rx_Valid & i_Rx_Ready;
    assign o_Busy          = (state != RX_IDLE);

    // Receive FSM, bit timing and the output holding register with its handshake.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state         <= RX_IDLE;
            bit_cnt       <= '0;
            bit_idx       <= '0;
            stop_idx      <= 1'b0;
            shift_reg     <= '0;
            parity_bit    <= 1'b0;
            frame_err_acc <= 1'b0;
            o_Rx_Data     <= '0;
            o_Rx_Valid    <= 1'b0;
            o_Parity_Err  <= 1'b0;
            o_Frame_Err   <= 1'b0;
            o_Overrun     <= 1'b0;
        end else begin
            // A completing frame below may override this consume.
            if (handshake) begin
                o_Rx_Valid <= 1'b0;
                o_Overrun  <= 1'b0;
            end

            case (state)
                RX_IDLE: begin
                    bit_cnt       <= '0;
                    bit_idx       <= '0;
                    stop_idx      <= 1'b0;
                    frame_err_acc <= 1'b0;
                    if (!rx_sync) begin
                        state <= RX_START;
                    end
                end

                RX_START: begin
                    if (bit_cnt == CNT_HALF) begin
                        bit_cnt <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                RX_DATA: begin
                    if (sample_pt) begin
                        bit_cnt            <= '0;
                        shift_reg[bit_idx] <= rx_sync;
                        if (bit_idx == BIT_LAST) begin
                            bit_idx <= '0;
                            state   <= (PARITY_MODE == PARITY_NONE) ? RX_STOP : RX_PARITY;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                RX_PARITY: begin
                    if (sample_pt) begin
                        bit_cnt    <= '0;
                        parity_bit <= rx_sync;
                        state      <= RX_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                RX_STOP: begin
                    if (sample_pt) begin
                        bit_cnt       <= '0;
                        frame_err_acc <= frame_err_calc;
                        if (stop_idx == STOP_LAST) begin
                            state <= RX_CLEANUP;
                            if (!o_Rx_Valid || i_Rx_Ready) begin
                                o_Rx_Data    <= shift_reg;
                                o_Parity_Err <= parity_err_calc;
                                o_Frame_Err  <= frame_err_calc;
                                o_Rx_Valid   <= 1'b1;
                            end else begin
                                o_Overrun <= 1'b1;
                            end
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                RX_CLEANUP: begin
                    if (rx_sync) begin
                        state <= RX_IDLE;
                    end
                end

                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench: three receiver configurations (8N1, 7E2, 9O1) on
// separate lines, directed corner cases plus random frames against a
// frame-level reference model.
module tb_uart_rx_param;

    localparam int CPB = 4;

    int nb_cfg[3] = '{8, 7, 9};
    int pm_cfg[3] = '{0, 1, 2};
    int ns_cfg[3] = '{1, 2, 1};

    logic       clk;
    logic       rst_n;
    logic [2:0] rx;
    logic [2:0] rdy;
    logic [2:0] vld;
    logic [2:0] perr;
    logic [2:0] ferr;
    logic [2:0] ovr;
    logic [2:0] busy;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic [8:0] data_c;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx[0]), .o_Rx_Data(data_a),
        .o_Rx_Valid(vld[0]), .i_Rx_Ready(rdy[0]), .o_Parity_Err(perr[0]),
        .o_Frame_Err(ferr[0]), .o_Overrun(ovr[0]), .o_Busy(busy[0]));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) dut_b (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx[1]), .o_Rx_Data(data_b),
        .o_Rx_Valid(vld[1]), .i_Rx_Ready(rdy[1]), .o_Parity_Err(perr[1]),
        .o_Frame_Err(ferr[1]), .o_Overrun(ovr[1]), .o_Busy(busy[1]));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY_MODE(2), .STOP_BITS(1)) dut_c (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx[2]), .o_Rx_Data(data_c),
        .o_Rx_Valid(vld[2]), .i_Rx_Ready(rdy[2]), .o_Parity_Err(perr[2]),
        .o_Frame_Err(ferr[2]), .o_Overrun(ovr[2]), .o_Busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic logic [8:0] get_data(input int sel);
        case (sel)
            0:       return {1'b0, data_a};
            1:       return {2'b0, data_b};
            default: return data_c;
        endcase
    endfunction

    function automatic logic [8:0] mask_bits(input logic [8:0] d, input int nb);
        logic [8:0] m;
        m = '0;
        for (int i = 0; i < nb; i++) m[i] = d[i];
        return m;
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input int sel, input string tag);
        chk({tag, "_flags"}, {4'b0, vld[sel], perr[sel], ferr[sel], ovr[sel], busy[sel]}, 9'h0);
        chk({tag, "_data"}, get_data(sel), 9'h0);
    endtask

    // Drive one frame: start, data LSB first, optional parity, stops.
    task automatic send_frame(input int sel, input logic [8:0] d, input bit flip,
                              input logic [1:0] sl, input logic end_level);
        logic       bq[$];
        logic [8:0] dm;
        logic       pbit;
        int         ones;
        dm   = mask_bits(d, nb_cfg[sel]);
        ones = $countones(dm);
        bq.push_back(1'b0);
        for (int i = 0; i < nb_cfg[sel]; i++) bq.push_back(dm[i]);
        if (pm_cfg[sel] != 0) begin
            pbit = (pm_cfg[sel] == 1) ? ((ones % 2) != 0) : ((ones % 2) == 0);
            bq.push_back(pbit ^ flip);
        end
        for (int j = 0; j < ns_cfg[sel]; j++) bq.push_back(~sl[j]);
        @(posedge clk); #1;
        foreach (bq[k]) begin
            rx[sel] = bq[k];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx[sel] = end_level;
    endtask

    task automatic wait_valid(input int sel, input int budget, input string tag);
        for (int i = 0; i < budget && vld[sel] !== 1'b1; i++) @(negedge clk);
        chk({tag, "_valid"}, {8'b0, vld[sel]}, 9'h1);
    endtask

    // Send, then compare the presented word and flags with the model.
    task automatic do_frame(input int sel, input logic [8:0] d, input bit flip,
                            input logic [1:0] sl, input string tag);
        logic [8:0] dm;
        logic       exp_perr;
        logic       exp_ferr;
        dm       = mask_bits(d, nb_cfg[sel]);
        exp_perr = (pm_cfg[sel] != 0) ? flip : 1'b0;
        exp_ferr = (ns_cfg[sel] == 2) ? (sl[0] | sl[1]) : sl[0];
        send_frame(sel, d, flip, sl, 1'b1);
        wait_valid(sel, 20, tag);
        chk({tag, "_data"}, get_data(sel), dm);
        chk({tag, "_perr"}, {8'b0, perr[sel]}, {8'b0, exp_perr});
        chk({tag, "_ferr"}, {8'b0, ferr[sel]}, {8'b0, exp_ferr});
        if (rdy[sel]) begin
            @(negedge clk);
            chk({tag, "_pulse"}, {8'b0, vld[sel]}, 9'h0);
        end
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic handshake(input int sel);
        @(posedge clk); #1 rdy[sel] = 1'b1;
        @(posedge clk); #1 rdy[sel] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int          vcount;
        bit          saw_busy;
        int          sel;
        logic [8:0]  d;
        bit          flip;
        logic [1:0]  sl;

        rst_n = 1'b0;
        rx    = 3'b111;
        rdy   = 3'b111;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) chk_zero(s, "reset");

        // Basic frames on each configuration
        do_frame(0, 9'h0A5, 1'b0, 2'b00, "a5_8n1");
        do_frame(1, 9'h035, 1'b1, 2'b00, "35_7e_bad_par");
        do_frame(1, 9'h035, 1'b0, 2'b00, "35_7e_good_par");
        do_frame(2, 9'h1C3, 1'b0, 2'b00, "1c3_9o_good");
        do_frame(2, 9'h1C3, 1'b1, 2'b00, "1c3_9o_bad_par");
        do_frame(0, 9'h0FF, 1'b0, 2'b01, "ff_8n1_bad_stop");

        // Second stop low, line held low afterwards: break holds the receiver
        rdy[1] = 1'b0;
        send_frame(1, 9'h02A, 1'b0, 2'b10, 1'b0);
        repeat (12) @(negedge clk);
        chk("break_valid", {8'b0, vld[1]}, 9'h1);
        chk("break_data", get_data(1), 9'h02A);
        chk("break_ferr", {8'b0, ferr[1]}, 9'h1);
        chk("break_perr", {8'b0, perr[1]}, 9'h0);
        chk("break_busy", {8'b0, busy[1]}, 9'h1);
        rx[1] = 1'b1;
        repeat (8) @(negedge clk);
        chk("break_release_busy", {8'b0, busy[1]}, 9'h0);
        chk("break_release_held", {8'b0, vld[1]}, 9'h1);
        handshake(1);
        chk("break_consumed", {8'b0, vld[1]}, 9'h0);
        repeat (10) @(negedge clk);
        chk("break_no_false_start", {7'b0, vld[1], busy[1]}, 9'h0);
        rdy[1] = 1'b1;

        // Overrun: hold first word, drop the second
        rdy[0] = 1'b0;
        do_frame(0, 9'h011, 1'b0, 2'b00, "ovr_first");
        chk("ovr_clear_first", {8'b0, ovr[0]}, 9'h0);
        send_frame(0, 9'h022, 1'b0, 2'b00, 1'b1);
        repeat (20) @(negedge clk);
        chk("ovr_held_data", get_data(0), 9'h011);
        chk("ovr_held_valid", {8'b0, vld[0]}, 9'h1);
        chk("ovr_set", {8'b0, ovr[0]}, 9'h1);
        handshake(0);
        chk("ovr_hs_valid", {8'b0, vld[0]}, 9'h0);
        chk("ovr_hs_clear", {8'b0, ovr[0]}, 9'h0);
        rdy[0] = 1'b1;

        // One-cycle glitch on an idle line
        @(posedge clk); #1 rx[0] = 1'b0;
        @(posedge clk); #1 rx[0] = 1'b1;
        vcount   = 0;
        saw_busy = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (vld[0]) vcount++;
            if (busy[0]) saw_busy = 1'b1;
        end
        chk("glitch_no_valid", 9'(vcount), 9'h0);
        chk("glitch_seen_start", {8'b0, saw_busy}, 9'h1);
        chk("glitch_idle", {8'b0, busy[0]}, 9'h0);

        // Random frames against the model
        for (int it = 0; it < 24; it++) begin
            sel  = it % 3;
            d    = 9'($urandom);
            flip = (pm_cfg[sel] != 0) && ($urandom_range(0, 3) == 0);
            sl   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            do_frame(sel, d, flip, sl, $sformatf("rand%0d", it));
        end

        // Reset during a frame, with another receiver holding an overrun
        rdy[2] = 1'b0;
        do_frame(2, 9'h155, 1'b0, 2'b00, "pre_rst_hold");
        send_frame(2, 9'h0AA, 1'b0, 2'b00, 1'b1);
        repeat (20) @(negedge clk);
        chk("pre_rst_ovr", {8'b0, ovr[2]}, 9'h1);
        @(posedge clk); #1 rx[0] = 1'b0;
        repeat (4 * CPB) @(posedge clk);
        #1;
        chk("mid_frame_busy", {8'b0, busy[0]}, 9'h1);
        rst_n = 1'b0;
        rx[0] = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) chk_zero(s, $sformatf("midrst%0d", s));
        @(posedge clk); #1 rst_n = 1'b1;
        rdy[2] = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_idle", {7'b0, vld[0], busy[0]}, 9'h0);
        do_frame(0, 9'h05A, 1'b0, 2'b00, "5a_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
